bundle_packer: RTL and testbench

- Encoder for the dual-issue 60-bit fetch bundle format; the inverse of the front-end bundle parser.
- Accepts a stream of single decoded-form instructions (format, branch, opcode, reg, operand) over a valid/ready handshake.
- Pairs consecutive instructions and emits a left-aligned 60-bit bundle with its byte size.
- Sits at the end of the program-image/test-generation path and in the instruction-memory fill path, feeding the fetch/parse stage.

---
 rtl/bundle_packer_if.sv | 34 +++
 rtl/bundle_packer.sv | 140 ++++++++++++++
 tb/tb_bundle_packer.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bundle_packer_if.sv
// ---------------------------------------------------------------------------
// bundle_packer_if
//   Instruction-in / bundle-out signal group for bundle_packer.
//   Instruction side : valid_i, ready_o, instructionFormat_i, isBranch_i,
//                      opcode_i[6:0], reg_i[4:0], operand_i[15:0]
//   Bundle side      : stall_i, bundle_o[59:0], bundleSize_o[3:0], enable_o
//   master = producer of instructions / consumer of bundles
//   slave  = the packer
// ---------------------------------------------------------------------------
interface bundle_packer_if;
    logic        valid_i;
    logic        ready_o;
    logic        instructionFormat_i;
    logic        isBranch_i;
    logic [6:0]  opcode_i;
    logic [4:0]  reg_i;
    logic [15:0] operand_i;
    logic        stall_i;
    logic [59:0] bundle_o;
    logic [3:0]  bundleSize_o;
    logic        enable_o;

    modport master (
        output valid_i, instructionFormat_i, isBranch_i, opcode_i, reg_i,
               operand_i, stall_i,
        input  ready_o, bundle_o, bundleSize_o, enable_o
    );

    modport slave (
        input  valid_i, instructionFormat_i, isBranch_i, opcode_i, reg_i,
               operand_i, stall_i,
        output ready_o, bundle_o, bundleSize_o, enable_o
    );
endinterface

// File: rtl/bundle_packer.sv
// ---------------------------------------------------------------------------
// bundle_packer
//   Pairs consecutive decoded instructions into a left-aligned 60-bit
//   dual-issue fetch bundle (the inverse of the front-end bundle parser).
//   A lone instruction is padded with a NOP on drain_i or after
//   PAIR_TIMEOUT cycles without a partner.
//
//   clock_i      clock, posedge
//   reset_i      synchronous active-high reset
//   flushBack_i  discards held instruction and pending bundle
//   drain_i      push a held lone instruction out with a NOP partner
//   bus          bundle_packer_if.slave (instruction in, bundle out)
//
//   state | meaning
//   ------+--------------------------------------------------------
//   EMPTY | no instruction held
//   HELD  | slot-A instruction held, wait_q counting toward timeout
// ---------------------------------------------------------------------------
module bundle_packer #(
    parameter logic [6:0] NOP_OPCODE   = 7'd0,
    parameter int         PAIR_TIMEOUT = 8
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             flushBack_i,
    input  logic             drain_i,
    bundle_packer_if.slave   bus
);

    localparam int CW = (PAIR_TIMEOUT > 1) ? $clog2(PAIR_TIMEOUT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(PAIR_TIMEOUT - 1);

    typedef enum logic {EMPTY, HELD} state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] wait_q, wait_d;

    // Instructions are kept in 30-bit slot-2 form: {fmt, br, op, reg, opnd16}
    // where a 19b-form operand sits in the top 5 bits of opnd16. That is
    // exactly the slot-2 image, and slot 1 just drops the low 11 bits.
    logic [29:0] held_q;
    logic [29:0] incoming;
    logic [29:0] slot_b;
    logic [59:0] packed_bundle;
    logic [3:0]  packed_size;

    logic        out_free;
    logic        accept;
    logic        pair_load;
    logic        pad_load;
    logic        load;

    logic [59:0] bundle_q;
    logic [3:0]  size_q;
    logic        enable_q;

    localparam logic [29:0] PAD_SLOT = {1'b0, 1'b0, NOP_OPCODE, 5'd0, 16'd0};

    // ---------------- state register and datapath ----------------
    always_ff @(posedge clock_i) begin
        if (reset_i || flushBack_i) begin
            state_q  <= EMPTY;
            wait_q   <= '0;
            held_q   <= '0;
            bundle_q <= '0;
            size_q   <= '0;
            enable_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (state_q == EMPTY && accept) begin
                held_q <= incoming;
            end
            if (load) begin
                bundle_q <= packed_bundle;
                size_q   <= packed_size;
                enable_q <= 1'b1;
            end else if (enable_q && !bus.stall_i) begin
                enable_q <= 1'b0;
            end
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = HELD;
                    wait_d  = '0;
                end
            end
            HELD: begin
                if (load) begin
                    state_d = EMPTY;
                end else if (wait_q != WAIT_LAST) begin
                    wait_d = wait_q + 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // ---------------- output / packing logic ----------------
    always_comb begin
        out_free = !enable_q || !bus.stall_i;
        accept   = bus.valid_i && out_free;

        incoming = {bus.instructionFormat_i, bus.isBranch_i, bus.opcode_i,
                    bus.reg_i,
                    bus.instructionFormat_i ? bus.operand_i
                                            : {bus.operand_i[4:0], 11'd0}};

        // An accept in HELD always pairs, so a same-cycle drain is moot.
        pair_load = (state_q == HELD) && accept;
        pad_load  = (state_q == HELD) && !accept && out_free &&
                    (drain_i || wait_q == WAIT_LAST);
        load      = pair_load || pad_load;

        slot_b = pair_load ? incoming : PAD_SLOT;

        if (held_q[29]) packed_bundle = {held_q, slot_b};
        else            packed_bundle = {held_q[29:11], slot_b, 11'd0};

        case ({held_q[29], slot_b[29]})
            2'b11:   packed_size = 4'd8;
            2'b10,
            2'b01:   packed_size = 4'd7;
            default: packed_size = 4'd5;
        endcase

        bus.ready_o      = out_free;
        bus.bundle_o     = bundle_q;
        bus.bundleSize_o = size_q;
        bus.enable_o     = enable_q;
    end

endmodule

// File: tb/tb_bundle_packer.sv
module tb_bundle_packer;

    localparam int         PT  = 8;
    localparam logic [6:0] NOP = 7'd0;

    typedef struct packed {
        logic        fmt;
        logic        br;
        logic [6:0]  op;
        logic [4:0]  rg;
        logic [15:0] opnd;
    } instr_t;

    localparam instr_t A30 = '{1'b1, 1'b0, 7'h12, 5'd3, 16'hBEEF};
    localparam instr_t B30 = '{1'b1, 1'b1, 7'h05, 5'd7, 16'h1234};
    localparam instr_t A19 = '{1'b0, 1'b0, 7'h01, 5'd2, 16'd9};
    localparam instr_t B19 = '{1'b0, 1'b0, 7'h02, 5'd4, 16'd17};

    // Hand-built expected bundles, field by field.
    localparam logic [59:0] L_30_30 = {1'b1,1'b0,7'h12,5'd3,16'hBEEF, 1'b1,1'b1,7'h05,5'd7,16'h1234};
    localparam logic [59:0] L_19_19 = {1'b0,1'b0,7'h01,5'd2,5'd9, 1'b0,1'b0,7'h02,5'd4,5'd17, 22'd0};
    localparam logic [59:0] L_30_19 = {1'b1,1'b0,7'h12,5'd3,16'hBEEF, 1'b0,1'b0,7'h02,5'd4,5'd17, 11'd0};
    localparam logic [59:0] L_19_30 = {1'b0,1'b0,7'h01,5'd2,5'd9, 1'b1,1'b1,7'h05,5'd7,16'h1234, 11'd0};
    localparam logic [59:0] L_PAD30 = {1'b1,1'b0,7'h12,5'd3,16'hBEEF, 19'd0, 11'd0};
    localparam logic [59:0] L_PAD19 = {1'b0,1'b0,7'h01,5'd2,5'd9, 19'd0, 22'd0};

    logic clock_i = 1'b0;
    logic reset_i;
    logic flushBack_i;
    logic drain_i;

    bundle_packer_if bus ();

    bundle_packer #(.NOP_OPCODE(NOP), .PAIR_TIMEOUT(PT)) dut (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .flushBack_i (flushBack_i),
        .drain_i     (drain_i),
        .bus         (bus)
    );

    always #5 clock_i = ~clock_i;

    int vectors     = 0;
    int miscompares = 0;
    bit run_cmp     = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic void put(inout logic [59:0] r, inout int pos,
                                input logic [15:0] v, input int w);
        for (int i = w - 1; i >= 0; i--) begin
            r[pos] = v[i];
            pos--;
        end
    endfunction

    function automatic int ilen(input instr_t x);
        return x.fmt ? 30 : 19;
    endfunction

    function automatic logic [59:0] m_pack(input instr_t a, input instr_t b);
        logic [59:0] r;
        int pos;
        r = '0;
        pos = 59;
        put(r, pos, 16'(a.fmt), 1);
        put(r, pos, 16'(a.br), 1);
        put(r, pos, 16'(a.op), 7);
        put(r, pos, 16'(a.rg), 5);
        if (a.fmt) put(r, pos, a.opnd, 16);
        else       put(r, pos, 16'(a.opnd[4:0]), 5);
        put(r, pos, 16'(b.fmt), 1);
        put(r, pos, 16'(b.br), 1);
        put(r, pos, 16'(b.op), 7);
        put(r, pos, 16'(b.rg), 5);
        if (b.fmt) put(r, pos, b.opnd, 16);
        else       put(r, pos, 16'(b.opnd[4:0]), 5);
        return r;
    endfunction

    instr_t      m_a;
    bit          m_have = 0;
    int          m_age  = 0;
    bit          m_en   = 0;
    logic [59:0] m_bundle = '0;
    logic [3:0]  m_size   = '0;

    always @(posedge clock_i) begin
        bit     rdy, acc, ld;
        instr_t inb, b2;
        rdy = !m_en || !bus.stall_i;
        acc = bus.valid_i && rdy;
        inb = '{bus.instructionFormat_i, bus.isBranch_i, bus.opcode_i, bus.reg_i, bus.operand_i};
        ld  = 0;
        b2  = '{1'b0, 1'b0, NOP, 5'd0, 16'd0};
        if (reset_i || flushBack_i) begin
            m_have = 0; m_age = 0; m_en = 0; m_bundle = '0; m_size = '0;
        end else begin
            if (acc && m_have) begin
                ld = 1; b2 = inb; m_have = 0;
            end else if (acc) begin
                m_have = 1; m_a = inb; m_age = 0;
            end else if (m_have && rdy && (drain_i || m_age >= PT - 1)) begin
                ld = 1; m_have = 0;
            end else if (m_have && m_age < PT - 1) begin
                m_age++;
            end
            if (ld) begin
                m_bundle = m_pack(m_a, b2);
                m_size   = 4'((ilen(m_a) + ilen(b2) + 7) / 8);
                m_en     = 1;
            end else if (m_en && !bus.stall_i) begin
                m_en = 0;
            end
        end
    end

    always @(negedge clock_i) begin
        if (run_cmp) begin
            chk("model_enable", 64'(bus.enable_o), 64'(m_en));
            chk("model_ready",  64'(bus.ready_o),  64'(!m_en || !bus.stall_i));
            chk("model_bundle", 64'(bus.bundle_o), 64'(m_bundle));
            chk("model_size",   64'(bus.bundleSize_o), 64'(m_size));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input instr_t x);
        bus.valid_i             = 1'b1;
        bus.instructionFormat_i = x.fmt;
        bus.isBranch_i          = x.br;
        bus.opcode_i            = x.op;
        bus.reg_i               = x.rg;
        bus.operand_i           = x.opnd;
    endtask

    task automatic send(input instr_t x);
        bit got, r;
        got = 0;
        drive(x);
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clock_i);
            r = bus.ready_o;
            @(posedge clock_i);
            got = r;
        end
        #1 bus.valid_i = 1'b0;
        if (!got) chk("send_timeout", 64'(got), 64'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock_i);
            #1;
        end
    endtask

    task automatic chk_out(input string name, input logic [59:0] b, input logic [3:0] s);
        chk({name, "_en"},   64'(bus.enable_o), 64'd1);
        chk({name, "_bits"}, 64'(bus.bundle_o), 64'(b));
        chk({name, "_size"}, 64'(bus.bundleSize_o), 64'(s));
    endtask

    initial begin
        reset_i = 1'b1; flushBack_i = 1'b0; drain_i = 1'b0;
        bus.valid_i = 1'b0; bus.stall_i = 1'b0;
        bus.instructionFormat_i = 1'b0; bus.isBranch_i = 1'b0;
        bus.opcode_i = '0; bus.reg_i = '0; bus.operand_i = '0;
        idle(2);
        reset_i = 1'b0;
        run_cmp = 1;
        chk("reset_en",     64'(bus.enable_o), 64'd0);
        chk("reset_bundle", 64'(bus.bundle_o), 64'd0);
        chk("reset_size",   64'(bus.bundleSize_o), 64'd0);
        chk("reset_ready",  64'(bus.ready_o), 64'd1);

        // pairing formats; enable must be up right after the B edge
        send(A30); chk("held_no_out", 64'(bus.enable_o), 64'd0);
        send(B30); chk_out("p30_30", L_30_30, 4'd8);
        idle(1);   chk("one_cycle_en", 64'(bus.enable_o), 64'd0);
        send(A19); send(B19); chk_out("p19_19", L_19_19, 4'd5);
        send(A30); send(B19); chk_out("p30_19", L_30_19, 4'd7);
        send(A19); send(B30); chk_out("p19_30", L_19_30, 4'd7);
        idle(2);

        // drain while empty does nothing
        drain_i = 1'b1; idle(2); drain_i = 1'b0;
        chk("empty_drain", 64'(bus.enable_o), 64'd0);

        // timeout: load exactly on the 8th edge after A
        send(A30);
        for (int i = 1; i <= PT; i++) begin
            idle(1);
            chk("timeout_en", 64'(bus.enable_o), 64'(i == PT));
        end
        chk_out("timeout", L_PAD30, 4'd7);
        idle(2);

        // drain at edge 2
        send(A19);
        idle(1); chk("pre_drain", 64'(bus.enable_o), 64'd0);
        drain_i = 1'b1; idle(1); drain_i = 1'b0;
        chk_out("drain", L_PAD19, 4'd5);
        idle(2);

        // drain coincident with B: pair wins
        send(A30);
        drain_i = 1'b1; send(B30); drain_i = 1'b0;
        chk_out("drain_pair", L_30_30, 4'd8);
        idle(2);

        // backpressure: bundle holds, C waits unconsumed
        send(A19); send(B19);
        bus.stall_i = 1'b1;
        drive(A30);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock_i);
            chk("bp_ready", 64'(bus.ready_o), 64'd0);
            chk_out("bp_hold", L_19_19, 4'd5);
        end
        @(posedge clock_i); #1 bus.stall_i = 1'b0;
        @(posedge clock_i); #1 bus.valid_i = 1'b0;
        chk("bp_release", 64'(bus.enable_o), 64'd0);
        send(B19); chk_out("bp_next", L_30_19, 4'd7);
        idle(2);

        // flush a stalled pending bundle
        send(A30); send(B30);
        bus.stall_i = 1'b1;
        idle(1);
        flushBack_i = 1'b1; idle(1); flushBack_i = 1'b0;
        chk("flush_en",     64'(bus.enable_o), 64'd0);
        chk("flush_bundle", 64'(bus.bundle_o), 64'd0);
        bus.stall_i = 1'b0;
        idle(1);

        // flush a held instruction; it must never reappear
        send(A30);
        flushBack_i = 1'b1; idle(1); flushBack_i = 1'b0;
        idle(PT + 3);
        chk("flush_held_gone", 64'(bus.enable_o), 64'd0);
        send(A19); send(B30); chk_out("after_flush", L_19_30, 4'd7);
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
